dsp_adder48_arb: RTL

Round-robin scheduler that shares one pipelined 48-bit DSP48E adder (dsp_adder48) between NREQ requesters. It accepts at most one operand pair per cycle and drives the adder's AIN1/BIN1. It tracks each issued operation's requester ID through a tag pipeline matched to the adder latency, and returns each 49-bit sum tagged with its requester ID. It sits between the requesting datapath blocks and the single dsp_adder48 instance in dsp48e_application.

---
 rtl/dsp_adder48_pkg.sv | 16 +
 rtl/dsp_adder48_arb_rr_arbiter.sv | 32 +++
 rtl/dsp_adder48_arb.sv | 66 ++++++
 3 files changed

// File: rtl/dsp_adder48_pkg.sv
// dsp_adder48_pkg: shared widths, tag type and helpers for the shared 48-bit adder scheduler
package dsp_adder48_pkg;
  localparam int ADD_W = 48;
  localparam int SUM_W = 49;
  localparam int ID_MAX_W = 3;
  typedef struct packed {
    logic                valid;
    logic [ID_MAX_W-1:0] id;
  } tag_t;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/dsp_adder48_arb_rr_arbiter.sv
// rr_arbiter: round-robin one-hot grant, priority rotating to the requester after the last winner
module rr_arbiter
  import dsp_adder48_pkg::*;
#(
  parameter int N = 4,
  localparam int IW = clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  input  logic          en,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_id
);
  logic [IW-1:0] last;
  logic [IW-1:0] idx;
  // Walk from the farthest candidate back to the nearest so the nearest valid one wins
  always_comb begin
    grant = '0;
    grant_id = '0;
    idx = '0;
    for (int k = N; k >= 1; k--) begin
      idx = IW'((int'(last) + k) % N);
      if (req[idx]) begin
        grant = '0;
        grant[idx] = 1'b1;
        grant_id = idx;
      end
    end
  end
  always_ff @(posedge clk) last <= rst ? IW'(N - 1) : en ? grant_id : last;
endmodule

// File: rtl/dsp_adder48_arb.sv
// dsp_adder48_arb: shares one pipelined 48-bit adder among NREQ requesters,
// tracking requester IDs alongside the adder pipeline and returning tagged sums.
module dsp_adder48_arb
  import dsp_adder48_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int ADD_LAT = 2,
  parameter int IDW = clog2(NREQ)
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [NREQ-1:0]       REQ_VALID,
  output logic [NREQ-1:0]       REQ_READY,
  input  logic [NREQ*ADD_W-1:0] REQ_A,
  input  logic [NREQ*ADD_W-1:0] REQ_B,
  output logic [ADD_W-1:0]      ADD_AIN1,
  output logic [ADD_W-1:0]      ADD_BIN1,
  input  logic [SUM_W-1:0]      ADD_OUT1,
  output logic                  RSP_VALID,
  output logic [IDW-1:0]        RSP_ID,
  output logic [SUM_W-1:0]      RSP_SUM,
  output logic                  BUSY
);
  localparam int GW = clog2(NREQ);
  logic [NREQ-1:0] grant;
  logic [GW-1:0]   gid;
  logic            hs;
  tag_t            tags [ADD_LAT];
  rr_arbiter #(.N(NREQ)) u_arb (
    .clk(CLK),
    .rst(RST),
    .req(REQ_VALID),
    .en(hs),
    .grant(grant),
    .grant_id(gid)
  );
  assign REQ_READY = RST ? '0 : grant;
  assign hs = |REQ_READY;
  always_ff @(posedge CLK) begin
    if (RST) begin
      ADD_AIN1 <= '0;
      ADD_BIN1 <= '0;
      for (int s = 0; s < ADD_LAT; s++) tags[s] <= '0;
      RSP_VALID <= 1'b0;
      RSP_ID <= '0;
      RSP_SUM <= '0;
    end else begin
      if (hs) begin
        ADD_AIN1 <= REQ_A[ADD_W*gid +: ADD_W];
        ADD_BIN1 <= REQ_B[ADD_W*gid +: ADD_W];
      end
      tags[0] <= '{valid: hs, id: ID_MAX_W'(gid)};
      for (int s = 1; s < ADD_LAT; s++) tags[s] <= tags[s-1];
      // The last tag stage lines up with the cycle ADD_OUT1 carries that operation's sum
      RSP_VALID <= tags[ADD_LAT-1].valid;
      if (tags[ADD_LAT-1].valid) begin
        RSP_ID <= IDW'(tags[ADD_LAT-1].id);
        RSP_SUM <= ADD_OUT1;
      end
    end
  end
  always_comb begin
    BUSY = RSP_VALID;
    for (int s = 0; s < ADD_LAT; s++) BUSY = BUSY | tags[s].valid;
  end
endmodule
